// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: multi-lane signed fixed-point multiplier with selectable rounding,
// saturate/wrap overflow handling, and a stall-together valid/ready pipeline.
module fp_mult_pipe #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned FRACTIONAL_BITS = 24,
    parameter int unsigned LANES           = 1,
    parameter int unsigned PIPE_STAGES     = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   din0,
    input  logic [LANES*DATA_WIDTH-1:0]   din1,
    input  logic                          round_en,
    input  logic                          sat_en,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*DATA_WIDTH-1:0]   dout,
    output logic [LANES-1:0]              ovf,
    input  logic                          ovf_clr,
    output logic                          ovf_sticky
);
    localparam int unsigned W   = DATA_WIDTH;
    localparam int unsigned PW2 = 2 * DATA_WIDTH;
    localparam int unsigned PW  = 2 * DATA_WIDTH + 1;
    localparam int unsigned BW  = LANES * DATA_WIDTH;
    localparam int unsigned HW  = PW - W + 1;
    localparam int unsigned RSH = (FRACTIONAL_BITS == 0) ? 0 : FRACTIONAL_BITS - 1;
    localparam logic signed [PW-1:0] RND_K = (FRACTIONAL_BITS == 0) ? '0 : (PW'(1) << RSH);
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    logic                  adv;
    logic                  s1_valid;
    logic                  s1_rnd;
    logic                  s1_sat;
    logic signed [PW2-1:0] s1_prod [LANES];
    logic signed [PW2-1:0] prod_c  [LANES];
    logic [BW-1:0]         res_c;
    logic [LANES-1:0]      ovf_c;

    logic                  v_q [2:PIPE_STAGES];
    logic [BW-1:0]         d_q [2:PIPE_STAGES];
    logic [LANES-1:0]      o_q [2:PIPE_STAGES];

    // Whole pipe advances together; a held output freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Full-width signed products per lane.
    always_comb begin
        for (int i = 0; i < int'(LANES); i++) begin
            prod_c[i] = PW2'($signed(din0[i*W +: W])) * PW2'($signed(din1[i*W +: W]));
        end
    end

    // Scale, round, range-check and saturate; one guard bit keeps the rounding add from wrapping.
    always_comb begin
        logic signed [PW-1:0] ext;
        logic signed [PW-1:0] q;
        logic [HW-1:0]        hi;
        res_c = '0;
        ovf_c = '0;
        ext   = '0;
        q     = '0;
        hi    = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            ext = PW'(s1_prod[i]);
            if (s1_rnd) begin
                ext = ext + RND_K;
            end
            q        = ext >>> FRACTIONAL_BITS;
            hi       = q[PW-1:W-1];
            ovf_c[i] = !((&hi) || !(|hi));
            if (ovf_c[i] && s1_sat) begin
                res_c[i*W +: W] = q[PW-1] ? MIN_NEG : MAX_POS;
            end else begin
                res_c[i*W +: W] = q[W-1:0];
            end
        end
    end

    // Stage 1 products, stage 2 results, remaining stages are pure delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_rnd   <= 1'b0;
            s1_sat   <= 1'b0;
            for (int i = 0; i < int'(LANES); i++) begin
                s1_prod[i] <= '0;
            end
            for (int k = 2; k <= int'(PIPE_STAGES); k++) begin
                v_q[k] <= 1'b0;
                d_q[k] <= '0;
                o_q[k] <= '0;
            end
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_rnd   <= round_en;
            s1_sat   <= sat_en;
            for (int i = 0; i < int'(LANES); i++) begin
                s1_prod[i] <= prod_c[i];
            end
            v_q[2] <= s1_valid;
            d_q[2] <= res_c;
            o_q[2] <= ovf_c;
            for (int k = 3; k <= int'(PIPE_STAGES); k++) begin
                v_q[k] <= v_q[k-1];
                d_q[k] <= d_q[k-1];
                o_q[k] <= o_q[k-1];
            end
        end
    end

    assign out_valid = v_q[PIPE_STAGES];
    assign dout      = d_q[PIPE_STAGES];
    assign ovf       = o_q[PIPE_STAGES];

    // Sticky overflow: a delivery with overflow beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (out_valid && out_ready && (|ovf)) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Bench for fp_mult_pipe: scoreboard of model results for a 1-lane/3-stage instance,
// plus a 4-lane/5-stage instance exercised directly.
module tb_fp_mult_pipe;

    typedef struct packed {
        logic [31:0] d;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] din0 = '0;
    logic [31:0] din1 = '0;
    logic        round_en = 1'b0;
    logic        sat_en = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] dout;
    logic [0:0]  ovf;
    logic        ovf_clr = 1'b0;
    logic        ovf_sticky;

    logic         b_in_valid = 1'b0;
    logic         b_in_ready;
    logic [127:0] b_din0 = '0;
    logic [127:0] b_din1 = '0;
    logic         b_round_en = 1'b0;
    logic         b_sat_en = 1'b0;
    logic         b_out_valid;
    logic         b_out_ready = 1'b1;
    logic [127:0] b_dout;
    logic [3:0]   b_ovf;
    logic         b_ovf_clr = 1'b0;
    logic         b_ovf_sticky;

    int   total = 0;
    int   passed = 0;
    int   deliveries = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    fp_mult_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .din0(din0), .din1(din1), .round_en(round_en), .sat_en(sat_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .ovf(ovf), .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky)
    );

    fp_mult_pipe #(.LANES(4), .PIPE_STAGES(5)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .din0(b_din0), .din1(b_din1), .round_en(b_round_en), .sat_en(b_sat_en),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .dout(b_dout), .ovf(b_ovf), .ovf_clr(b_ovf_clr), .ovf_sticky(b_ovf_sticky)
    );

    // Reference: Q8.24 product in 64-bit integer arithmetic.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic rnd, input logic sat);
        longint p;
        longint q;
        exp_t   e;
        p = longint'($signed(a)) * longint'($signed(b));
        if (rnd) p = p + 64'sd8388608;
        q = p >>> 24;
        e.ovf = (q > 64'sd2147483647) || (q < -64'sd2147483648);
        if (e.ovf && sat) e.d = (q < 0) ? 32'h8000_0000 : 32'h7fff_ffff;
        else              e.d = q[31:0];
        return e;
    endfunction

    // Output monitor: every delivered beat must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            deliveries++;
            total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_beat dout=%h ovf=%b (no beat outstanding)", dout, ovf);
            end else begin
                e = sb.pop_front();
                if ({dout, ovf} !== {e.d, e.ovf})
                    $display("FAIL scoreboard dout=%h ovf=%b expected dout=%h ovf=%b",
                             dout, ovf, e.d, e.ovf);
                else passed++;
            end
        end
    end

    // Present one beat, hold it until accepted, then record its expected result.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic rnd, input logic sat);
        bit ok = 0;
        bit acc;
        din0 = a; din1 = b; round_en = rnd; sat_en = sat; in_valid = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) ok = 1;
        end
        if (ok) sb.push_back(model(a, b, rnd, sat));
        else begin
            total++;
            $display("FAIL accept_timeout in_ready=%b expected 1 within 200 cycles", in_ready);
        end
    endtask

    task automatic drain(output bit ok);
        in_valid = 1'b0;
        ok = 0;
        for (int n = 0; n < 100 && !ok; n++) begin
            if (sb.size() == 0 && !out_valid) ok = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset;
        #12;
        total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b want=0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b want=1", in_ready); else passed++;
        total++; if (dout !== 32'h0) $display("FAIL rst_dout got=%h want=0", dout); else passed++;
        total++; if (ovf !== 1'b0) $display("FAIL rst_ovf got=%b want=0", ovf); else passed++;
        total++; if (ovf_sticky !== 1'b0) $display("FAIL rst_sticky got=%b want=0", ovf_sticky); else passed++;
        total++; if (b_out_valid !== 1'b0) $display("FAIL rst_b_out_valid got=%b want=0", b_out_valid); else passed++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Latency counted in cycles from the cycle the beat is presented and accepted.
    task automatic test_basic;
        int lat;
        bit ok;
        send(32'h0180_0000, 32'h0200_0000, 1'b0, 1'b1);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        total++; if (lat != 3) $display("FAIL basic_latency got=%0d want=3", lat); else passed++;
        total++; if (dout !== 32'h0300_0000) $display("FAIL basic_dout got=%h want=03000000", dout); else passed++;
        drain(ok);
        total++; if (!ok) $display("FAIL basic_drain outstanding=%0d want=0", sb.size()); else passed++;
    endtask

    task automatic test_rounding;
        bit ok;
        for (int m = 0; m < 2; m++) begin
            send(32'h0000_0001, 32'h0080_0000, 1'(m), 1'b1);
            send(32'hFF00_0000, 32'h0080_0000, 1'(m), 1'b1);
            send(32'hFFFF_FFFF, 32'h0080_0000, 1'(m), 1'b0);
        end
        drain(ok);
        total++; if (!ok) $display("FAIL round_drain outstanding=%0d want=0", sb.size()); else passed++;
    endtask

    task automatic test_overflow;
        bit ok;
        total++; if (ovf_sticky !== 1'b0) $display("FAIL ovf_sticky_pre got=%b want=0", ovf_sticky); else passed++;
        send(32'h6400_0000, 32'h0200_0000, 1'b0, 1'b1);
        send(32'h6400_0000, 32'h0200_0000, 1'b0, 1'b0);
        send(32'h8000_0000, 32'hFF00_0000, 1'b1, 1'b1);
        drain(ok);
        total++; if (!ok) $display("FAIL ovf_drain outstanding=%0d want=0", sb.size()); else passed++;
        total++; if (ovf_sticky !== 1'b1) $display("FAIL ovf_sticky_set got=%b want=1", ovf_sticky); else passed++;
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        total++; if (ovf_sticky !== 1'b0) $display("FAIL ovf_sticky_clr got=%b want=0", ovf_sticky); else passed++;
    endtask

    task automatic test_backpressure;
        bit ok;
        int d0;
        d0 = deliveries;
        fork
            begin
                for (int k = 0; k < 6; k++) send(32'(k + 1) << 24, 32'h0200_0000, 1'b0, 1'b1);
                in_valid = 1'b0;
            end
            begin
                logic [31:0] held;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                held = dout;
                for (int c = 0; c < 5; c++) begin
                    if (c > 0) @(negedge clk);
                    total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got=%b want=0", in_ready); else passed++;
                    total++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid got=%b want=1", out_valid); else passed++;
                    total++; if (dout !== held) $display("FAIL bp_dout_stable got=%h want=%h", dout, held); else passed++;
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain(ok);
        total++; if (!ok) $display("FAIL bp_drain outstanding=%0d want=0", sb.size()); else passed++;
        total++; if (deliveries - d0 != 6) $display("FAIL bp_count got=%0d want=6", deliveries - d0); else passed++;
    endtask

    task automatic test_back_to_back;
        bit ok;
        fork
            begin
                for (int k = 0; k < 16; k++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    send($urandom, $urandom >> $urandom_range(0, 31),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain(ok);
        total++; if (!ok) $display("FAIL b2b_drain outstanding=%0d want=0", sb.size()); else passed++;
    endtask

    task automatic test_lanes;
        logic [31:0] a [4];
        logic [31:0] b [4];
        exp_t        e;
        logic [3:0]  eo;
        int          lat;
        a[0] = 32'h0180_0000; b[0] = 32'h0200_0000;
        a[1] = 32'hFF00_0000; b[1] = 32'h0080_0000;
        a[2] = 32'h6400_0000; b[2] = 32'h0200_0000;
        a[3] = 32'h0000_0001; b[3] = 32'h0080_0000;
        for (int i = 0; i < 4; i++) begin
            b_din0[i*32 +: 32] = a[i];
            b_din1[i*32 +: 32] = b[i];
        end
        b_round_en = 1'b1;
        b_sat_en = 1'b1;
        total++; if (b_in_ready !== 1'b1) $display("FAIL lanes_in_ready got=%b want=1", b_in_ready); else passed++;
        b_in_valid = 1'b1;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        lat = 1;
        while (!b_out_valid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        total++; if (lat != 5) $display("FAIL lanes_latency got=%0d want=5", lat); else passed++;
        eo = '0;
        for (int i = 0; i < 4; i++) begin
            e = model(a[i], b[i], 1'b1, 1'b1);
            eo[i] = e.ovf;
            total++;
            if (b_dout[i*32 +: 32] !== e.d)
                $display("FAIL lanes_dout lane=%0d got=%h want=%h", i, b_dout[i*32 +: 32], e.d);
            else passed++;
        end
        total++; if (b_ovf !== eo) $display("FAIL lanes_ovf got=%b want=%b", b_ovf, eo); else passed++;
        @(posedge clk);
        #1;
        total++; if (b_ovf_sticky !== 1'b1) $display("FAIL lanes_sticky got=%b want=1", b_ovf_sticky); else passed++;
        total++; if (b_out_valid !== 1'b0) $display("FAIL lanes_single_beat got=%b want=0", b_out_valid); else passed++;
    endtask

    task automatic test_reset_midstream;
        bit ok;
        bit seen;
        send(32'h6400_0000, 32'h0200_0000, 1'b0, 1'b1);
        drain(ok);
        total++; if (ovf_sticky !== 1'b1) $display("FAIL mid_sticky_pre got=%b want=1", ovf_sticky); else passed++;
        send(32'h0180_0000, 32'h0200_0000, 1'b0, 1'b1);
        send(32'h0100_0000, 32'h0300_0000, 1'b0, 1'b1);
        send(32'h0200_0000, 32'h0300_0000, 1'b0, 1'b1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        sb.delete();
        total++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid got=%b want=0", out_valid); else passed++;
        total++; if (ovf_sticky !== 1'b0) $display("FAIL mid_sticky got=%b want=0", ovf_sticky); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready got=%b want=1", in_ready); else passed++;
        total++; if (dout !== 32'h0) $display("FAIL mid_dout got=%h want=0", dout); else passed++;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        total++; if (seen !== 1'b0) $display("FAIL mid_stale_beat got=%b want=0", seen); else passed++;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_rounding;
        test_overflow;
        test_backpressure;
        test_back_to_back;
        test_lanes;
        test_reset_midstream;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
